lms_sample_scheduler: RTL and testbench

- Sequences one LMS noise-filter iteration per sample pair.
- Pops one primary sample d[n] and one reference sample x[n] from two show-ahead sync FIFOs, launches the LMS core, and waits for its done strobe with a watchdog.
- Writes the error sample e[n] to an output FIFO, with back-pressure.
- Owns the FIFO clear, so a flush is atomic with respect to the core; sits between the ADC-side FIFOs, the LMS core and the output FIFO.

---
 rtl/lms_sched_pkg.sv | 9 +
 rtl/lms_sample_scheduler_watchdog.sv | 29 ++
 rtl/lms_sample_scheduler.sv | 118 +++++++++++
 tb/tb_lms_sample_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_sched_pkg.sv
// Shared types and constants for the LMS sample scheduler.
package lms_sched_pkg;

  typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, FLUSH} sched_state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int SAMPLE_CNT_W  = 32;

endpackage

// File: rtl/lms_sample_scheduler_watchdog.sv
// Watchdog counter for the scheduler's WAIT state; expired flags the increment
// that brings the count to TIMEOUT.
module lms_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && count_reg != CW'(TIMEOUT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = inc && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lms_sample_scheduler.sv
// Sequences one LMS iteration per (d, x) sample pair: pop both FIFOs, start the
// core, wait for done under a watchdog, write e to the output FIFO, and own flushes.
module lms_sample_scheduler
  import lms_sched_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    pri_empty,
  input  logic [WIDTH-1:0]        pri_rd_data,
  output logic                    pri_rd_en,
  input  logic                    ref_empty,
  input  logic [WIDTH-1:0]        ref_rd_data,
  output logic                    ref_rd_en,
  output logic                    core_start,
  output logic [WIDTH-1:0]        core_d,
  output logic [WIDTH-1:0]        core_x,
  input  logic                    core_done,
  input  logic [WIDTH-1:0]        core_e,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [WIDTH-1:0]        out_wr_data,
  output logic                    fifo_clr,
  output logic                    busy,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt,
  output logic                    timeout_err
);

  sched_state_t state_reg, state_next;
  logic         flush_pend_reg;
  logic         live;
  logic         pop;
  logic         wd_clr;
  logic         wd_inc;
  logic         wd_expired;

  // Strobes are suppressed while reset is held so nothing is popped or written.
  assign live = clk_en && rst_n;

  assign pop = (state_reg == IDLE) && !flush && !flush_pend_reg && enable
               && !pri_empty && !ref_empty;

  assign pri_rd_en  = live && pop;
  assign ref_rd_en  = live && pop;
  assign core_start = live && (state_reg == START);
  assign out_wr_en  = live && (state_reg == WRITE) && !flush_pend_reg && !out_full;
  assign fifo_clr   = live && (state_reg == FLUSH);
  assign busy       = (state_reg != IDLE);

  assign wd_clr = live && (state_reg == START);
  assign wd_inc = live && (state_reg == WAIT) && !core_done;

  lms_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (flush || flush_pend_reg) state_next = FLUSH;
        else if (pop)                state_next = START;
      end
      START: state_next = WAIT;
      WAIT: begin
        if (core_done)       state_next = WRITE;
        else if (wd_expired) state_next = IDLE;
      end
      WRITE: begin
        if (flush_pend_reg) state_next = FLUSH;
        else if (!out_full) state_next = IDLE;
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      flush_pend_reg <= 1'b0;
      core_d         <= '0;
      core_x         <= '0;
      out_wr_data    <= '0;
      sample_cnt     <= '0;
      timeout_err    <= 1'b0;
    end else if (clk_en) begin
      state_reg <= state_next;
      if (pop) begin
        core_d <= pri_rd_data;
        core_x <= ref_rd_data;
      end
      if (state_reg == WAIT && core_done) out_wr_data <= core_e;
      if (wd_expired) timeout_err <= 1'b1;
      // A flush arriving mid-iteration (including WRITE) is remembered so a pulse is never lost.
      if (state_reg == FLUSH) begin
        flush_pend_reg <= 1'b0;
        sample_cnt     <= '0;
        timeout_err    <= 1'b0;
      end else begin
        if (flush && (state_reg inside {START, WAIT, WRITE})) flush_pend_reg <= 1'b1;
        if (out_wr_en) sample_cnt <= sample_cnt + SAMPLE_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lms_sample_scheduler.sv
// Directed and randomized bench for lms_sample_scheduler with FIFO/core models
// and a transaction scoreboard of expected e = d - x values.
module tb_lms_sample_scheduler;

  localparam int W  = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clk_en, enable, flush;
  logic          pri_empty, ref_empty, pri_rd_en, ref_rd_en;
  logic [W-1:0]  pri_rd_data, ref_rd_data, core_d, core_x, core_e, out_wr_data;
  logic          core_start, core_done, out_full, out_wr_en, fifo_clr, busy, timeout_err;
  logic [31:0]   sample_cnt;

  lms_sample_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .enable(enable), .flush(flush),
    .pri_empty(pri_empty), .pri_rd_data(pri_rd_data), .pri_rd_en(pri_rd_en),
    .ref_empty(ref_empty), .ref_rd_data(ref_rd_data), .ref_rd_en(ref_rd_en),
    .core_start(core_start), .core_d(core_d), .core_x(core_x),
    .core_done(core_done), .core_e(core_e),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_wr_data(out_wr_data),
    .fifo_clr(fifo_clr), .busy(busy), .sample_cnt(sample_cnt), .timeout_err(timeout_err)
  );

  // Environment: FIFO contents, core latency, expected outputs.
  logic [W-1:0] pri_q[$], ref_q[$], pend_q[$];
  int           pop_log[$];
  int           core_cnt, core_lat;
  logic [W-1:0] core_e_val, exp_d, exp_x, last_wr_data;
  logic [31:0]  exp_cnt;
  int           n_assert, n_fail;
  int           en_idx, pop_at, start_at, wr_at, clr_at, n_pop, n_wr, n_clr;
  logic         s_rd, s_start, s_wr, s_clr;
  logic [W-1:0] s_core_d, s_core_x;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive environment, sample strobes before the edge, update models after it.
  task automatic tick();
    pri_empty   = (pri_q.size() == 0);
    ref_empty   = (ref_q.size() == 0);
    pri_rd_data = pri_empty ? '0 : pri_q[0];
    ref_rd_data = ref_empty ? '0 : ref_q[0];
    core_done   = (core_cnt == 1);
    core_e      = core_e_val;
    #1;
    s_rd = pri_rd_en; s_start = core_start; s_wr = out_wr_en; s_clr = fifo_clr;
    s_core_d = core_d; s_core_x = core_x;
    check("pop_pair", 64'(ref_rd_en), 64'(pri_rd_en));
    if (!(clk_en && rst_n))
      check("gated_strobes", 64'({pri_rd_en, core_start, out_wr_en, fifo_clr}), 64'd0);
    if (s_rd) check("pop_nonempty", 64'(pri_empty || ref_empty), 64'd0);
    if (s_start) begin
      check("core_d", 64'(s_core_d), 64'(exp_d));
      check("core_x", 64'(s_core_x), 64'(exp_x));
    end
    if (s_wr) begin
      check("wr_expected", 64'(pend_q.size() != 0), 64'd1);
      if (pend_q.size() != 0) check("wr_data", 64'(out_wr_data), 64'(pend_q.pop_front()));
      last_wr_data = out_wr_data;
    end
    @(posedge clk);
    if (!rst_n) begin
      core_cnt = 0; pend_q.delete(); exp_cnt = 0;
    end else if (clk_en) begin
      if (core_cnt > 0) core_cnt--;
      if (s_rd) begin
        exp_d = pri_q[0]; exp_x = ref_q[0];
        pend_q.push_back(pri_q[0] - ref_q[0]);
        void'(pri_q.pop_front()); void'(ref_q.pop_front());
        n_pop++; pop_at = en_idx; pop_log.push_back(en_idx);
      end
      if (s_start) begin
        core_cnt = core_lat; core_e_val = s_core_d - s_core_x; start_at = en_idx;
      end
      if (s_wr) begin n_wr++; wr_at = en_idx; exp_cnt++; end
      if (s_clr) begin
        n_clr++; clr_at = en_idx; exp_cnt = 0;
        pri_q.delete(); ref_q.delete(); pend_q.delete();
      end
      en_idx++;
    end
    @(negedge clk);
  endtask

  task automatic push_pair(input logic [W-1:0] d, input logic [W-1:0] x);
    pri_q.push_back(d); ref_q.push_back(x);
  endtask

  task automatic run_until_writes(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && n_wr < target; k++) tick();
    check(tag, 64'(n_wr >= target), 64'd1);
  endtask

  task automatic run_until_pops(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && n_pop < target; k++) tick();
    check(tag, 64'(n_pop >= target), 64'd1);
  endtask

  initial begin
    int wr0, p0, c0;
    logic [W-1:0] d, x, exp_e;
    n_assert = 0; n_fail = 0; en_idx = 0; n_pop = 0; n_wr = 0; n_clr = 0;
    pop_at = 0; start_at = 0; wr_at = 0; clr_at = 0;
    core_cnt = 0; core_lat = 1; core_e_val = '0; exp_cnt = 0; exp_d = '0; exp_x = '0;
    last_wr_data = '0;
    rst_n = 1'b0; clk_en = 1'b1; enable = 1'b0; flush = 1'b0; out_full = 1'b0;
    pri_empty = 1'b1; ref_empty = 1'b1; pri_rd_data = '0; ref_rd_data = '0;
    core_done = 1'b0; core_e = '0;
    @(negedge clk);
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_d", 64'(core_d), 64'd0);
    check("rst_core_x", 64'(core_x), 64'd0);
    check("rst_wr_data", 64'(out_wr_data), 64'd0);
    check("rst_cnt", 64'(sample_cnt), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // Single sample with 1-cycle core
    enable = 1'b1; core_lat = 1;
    push_pair(16'h0100, 16'h0020);
    run_until_writes(1, 20, "single_budget");
    check("single_start_at", 64'(start_at - pop_at), 64'd1);
    check("single_wr_at", 64'(wr_at - pop_at), 64'd3);
    check("single_data", 64'(last_wr_data), 64'h00E0);
    check("single_cnt", 64'(sample_cnt), 64'd1);

    // Back-to-back: 8 pairs
    pop_log.delete(); p0 = n_pop;
    for (int i = 0; i < 8; i++) push_pair(W'($urandom), W'($urandom));
    run_until_writes(9, 60, "b2b_budget");
    tick();
    check("b2b_pops", 64'(n_pop - p0), 64'd8);
    check("b2b_cnt", 64'(sample_cnt), 64'd9);
    check("b2b_busy", 64'(busy), 64'd0);
    for (int i = 1; i < pop_log.size(); i++)
      check("b2b_spacing", 64'(pop_log[i] - pop_log[i-1]), 64'd4);

    // Back-pressure in WRITE for 10 cycles
    out_full = 1'b1; d = W'($urandom); x = W'($urandom); exp_e = d - x;
    p0 = n_pop; push_pair(d, x);
    run_until_pops(p0 + 1, 10, "bp_pop_budget");
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_no_wr", 64'(s_wr), 64'd0);
      check("bp_data_stable", 64'(out_wr_data), 64'(exp_e));
    end
    out_full = 1'b0; tick();
    check("bp_wr", 64'(s_wr), 64'd1);
    check("bp_cnt", 64'(sample_cnt), 64'd10);

    // Watchdog: core never completes
    core_lat = 0; wr0 = n_wr; p0 = n_pop;
    push_pair(W'($urandom), W'($urandom));
    run_until_pops(p0 + 1, 10, "wd_pop_budget");
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    check("wd_no_err_early", 64'(timeout_err), 64'd0);
    check("wd_busy_early", 64'(busy), 64'd1);
    tick();
    check("wd_err", 64'(timeout_err), 64'd1);
    check("wd_idle", 64'(busy), 64'd0);
    check("wd_no_wr", 64'(n_wr - wr0), 64'd0);
    void'(pend_q.pop_front());
    flush = 1'b1; tick(); flush = 1'b0; tick();
    check("flush_clr", 64'(s_clr), 64'd1);
    check("flush_err_clr", 64'(timeout_err), 64'd0);
    check("flush_cnt_clr", 64'(sample_cnt), 64'd0);

    // Done on the TIMEOUT-th WAIT cycle wins
    core_lat = TO;
    push_pair(W'($urandom), W'($urandom));
    run_until_writes(n_wr + 1, TO + 20, "wd64_budget");
    check("wd64_no_err", 64'(timeout_err), 64'd0);
    check("wd64_start_to_wr", 64'(wr_at - start_at), 64'(TO + 1));

    // Done one cycle too late: error, and the late done in IDLE is ignored
    core_lat = TO + 1; wr0 = n_wr; p0 = n_pop;
    push_pair(W'($urandom), W'($urandom));
    run_until_pops(p0 + 1, 10, "wd65_pop_budget");
    tick();
    for (int i = 0; i < TO; i++) tick();
    check("wd65_err", 64'(timeout_err), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    check("late_done_ignored", 64'(n_wr - wr0), 64'd0);
    check("late_done_idle", 64'(busy), 64'd0);
    void'(pend_q.pop_front());
    flush = 1'b1; tick(); flush = 1'b0; tick();

    // Flush pulse during WAIT
    core_lat = 5; wr0 = n_wr; c0 = n_clr; p0 = n_pop;
    push_pair(W'($urandom), W'($urandom));
    push_pair(W'($urandom), W'($urandom));
    run_until_pops(p0 + 1, 10, "mf_pop_budget");
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 20 && n_clr == c0; i++) tick();
    check("mf_clr_once", 64'(n_clr - c0), 64'd1);
    check("mf_no_wr", 64'(n_wr - wr0), 64'd0);
    check("mf_cnt", 64'(sample_cnt), 64'd0);
    check("mf_done_then_clr", 64'(clr_at - start_at), 64'd7);
    check("mf_no_err", 64'(timeout_err), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("mf_no_pop_after", 64'(n_pop - p0), 64'd1);
    check("mf_single_clr", 64'(n_clr - c0), 64'd1);

    // Random clk_en gating stretches the same sequence
    core_lat = 1; wr0 = n_wr;
    push_pair(W'($urandom), W'($urandom));
    for (int i = 0; i < 200 && n_wr == wr0; i++) begin
      clk_en = 1'($urandom_range(0, 1));
      tick();
    end
    clk_en = 1'b1;
    check("gate_wr", 64'(n_wr - wr0), 64'd1);
    check("gate_start_at", 64'(start_at - pop_at), 64'd1);
    check("gate_wr_at", 64'(wr_at - pop_at), 64'd3);
    check("gate_cnt", 64'(sample_cnt), 64'd1);

    // Reset while in WAIT
    core_lat = 0; p0 = n_pop; c0 = n_clr;
    push_pair(W'($urandom) | W'(1), W'($urandom) | W'(1));
    run_until_pops(p0 + 1, 10, "rw_pop_budget");
    tick(); tick();
    check("rw_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0; tick();
    check("rw_no_clr", 64'(n_clr - c0), 64'd0);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_core_d", 64'(core_d), 64'd0);
    check("rw_core_x", 64'(core_x), 64'd0);
    check("rw_wr_data", 64'(out_wr_data), 64'd0);
    check("rw_cnt", 64'(sample_cnt), 64'd0);
    check("rw_err", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // Randomized traffic: latency, back-pressure and clk_en all random
    wr0 = n_wr;
    for (int i = 0; i < 20; i++) push_pair(W'($urandom), W'($urandom));
    for (int i = 0; i < 2000 && n_wr < wr0 + 20; i++) begin
      core_lat = int'($urandom_range(1, 8));
      out_full = ($urandom_range(0, 3) == 0);
      clk_en   = ($urandom_range(0, 7) != 0);
      tick();
    end
    clk_en = 1'b1; out_full = 1'b0;
    tick();
    check("rnd_writes", 64'(n_wr - wr0), 64'd20);
    check("rnd_cnt", 64'(sample_cnt), 64'(exp_cnt));
    check("rnd_cnt_abs", 64'(sample_cnt), 64'd20);
    check("rnd_pend_empty", 64'(pend_q.size()), 64'd0);
    check("rnd_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
